// File: rtl/nib3_pack_arbiter_if.sv
// Bus bundle for the three-requester nibble packer: per-requester request,
// nibble data, grant and word counter, the configuration write port and the
// packed byte output with its valid/ready handshake.
interface nib3_pack_arbiter_if #(
    parameter int DW = 4,
    parameter int CW = 4
);
    logic            req0, req1, req2;
    logic [DW-1:0]   dat0, dat1, dat2;
    logic [7:0]      cfg_data;
    logic            cfg_we;
    logic            out_rdy;
    logic            gnt0, gnt1, gnt2;
    logic [CW-1:0]   cnt0, cnt1, cnt2;
    logic [2*DW-1:0] out_data;
    logic            out_vld;

    // Side that drives requests, configuration and downstream ready.
    modport master (
        output req0, req1, req2, dat0, dat1, dat2, cfg_data, cfg_we, out_rdy,
        input  gnt0, gnt1, gnt2, cnt0, cnt1, cnt2, out_data, out_vld
    );

    // The arbiter itself.
    modport slave (
        input  req0, req1, req2, dat0, dat1, dat2, cfg_data, cfg_we, out_rdy,
        output gnt0, gnt1, gnt2, cnt0, cnt1, cnt2, out_data, out_vld
    );
endinterface

// File: rtl/nib3_pack_arbiter.sv
// Three-way nibble packer. An owner is chosen in IDLE (round-robin or fixed
// priority, masked by the enable field), then supplies a low and a high nibble
// per word for up to burst-length words. Packed bytes go out through a single
// registered valid/ready stage; per-requester saturating counters count words.
module nib3_pack_arbiter #(
    parameter int         DW      = 4,
    parameter int         CW      = 4,
    parameter logic [7:0] CFG_RST = 8'h71
) (
    input logic                 clk,
    input logic                 rst,
    nib3_pack_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    // Registered state
    state_t          state;
    logic [1:0]      owner;
    logic [1:0]      rr_ptr;
    logic [4:0]      burst_len;   // 1..16 words, latched at grant
    logic [4:0]      burst_cnt;   // words completed in the current burst
    logic [DW-1:0]   lo_nib;
    logic [7:0]      cfg;
    logic [2*DW-1:0] out_data_q;
    logic            out_vld_q;
    logic [CW-1:0]   cnt_q [3];

    // Combinational decode
    logic            free;
    logic            busy;
    logic            req_own;
    logic [DW-1:0]   dat_own;
    logic            owner_en;
    logic            xfer;
    logic            load;
    logic            burst_done;
    logic [2:0]      elig;
    logic            win_vld;
    logic [1:0]      win_idx;
    logic [4:0]      cfg_len;
    logic [1:0]      next_ptr;

    // The output stage can accept a new word when empty or draining this cycle;
    // every state transition waits on it so a stall freezes the whole block.
    assign free     = !out_vld_q || bus.out_rdy;
    assign busy     = (state == LO) || (state == HI);
    assign elig     = {bus.req2, bus.req1, bus.req0} & cfg[6:4];
    assign cfg_len  = (cfg[3:0] == 4'd0) ? 5'd16 : {1'b0, cfg[3:0]};
    assign xfer     = busy && free && req_own;
    assign load     = (state == HI) && xfer;
    assign next_ptr = (owner == 2'd2) ? 2'd0 : owner + 2'd1;

    // A word completing the burst, or an owner whose enable was withdrawn,
    // hands the channel back to arbitration.
    assign burst_done = ((burst_cnt + 5'd1) == burst_len) || !owner_en;

    // Select the current owner's request, nibble and enable bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        req_own  = 1'b0;
        dat_own  = '0;
        owner_en = 1'b0;
        case (owner)
            2'd0: begin
                req_own  = bus.req0;
                dat_own  = bus.dat0;
                owner_en = cfg[4];
            end
            2'd1: begin
                req_own  = bus.req1;
                dat_own  = bus.dat1;
                owner_en = cfg[5];
            end
            2'd2: begin
                req_own  = bus.req2;
                dat_own  = bus.dat2;
                owner_en = cfg[6];
            end
            default: ;
        endcase
    end

    // Pick the winner among eligible requesters: lowest index in fixed-priority
    // mode, otherwise the first eligible at or after the round-robin pointer.
    always_comb begin
        win_vld = |elig;
        win_idx = 2'd0;
        if (cfg[7]) begin
            if (elig[0])      win_idx = 2'd0;
            else if (elig[1]) win_idx = 2'd1;
            else if (elig[2]) win_idx = 2'd2;
        end else begin
            case (rr_ptr)
                2'd1: begin
                    if (elig[1])      win_idx = 2'd1;
                    else if (elig[2]) win_idx = 2'd2;
                    else if (elig[0]) win_idx = 2'd0;
                end
                2'd2: begin
                    if (elig[2])      win_idx = 2'd2;
                    else if (elig[0]) win_idx = 2'd0;
                    else if (elig[1]) win_idx = 2'd1;
                end
                default: begin
                    if (elig[0])      win_idx = 2'd0;
                    else if (elig[1]) win_idx = 2'd1;
                    else if (elig[2]) win_idx = 2'd2;
                end
            endcase
        end
    end

    // Grants are only offered while a word is in progress and the output can take it.
    assign bus.gnt0 = busy && (owner == 2'd0) && free;
    assign bus.gnt1 = busy && (owner == 2'd1) && free;
    assign bus.gnt2 = busy && (owner == 2'd2) && free;

    // Ownership FSM: arbitrate, collect low nibble, collect high nibble.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            rr_ptr    <= 2'd0;
            burst_len <= 5'd0;
            burst_cnt <= 5'd0;
            lo_nib    <= '0;
        end else if (free) begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner     <= win_idx;
                        burst_len <= cfg_len;
                        burst_cnt <= 5'd0;
                        state     <= LO;
                    end
                end
                LO: begin
                    if (req_own) begin
                        lo_nib <= dat_own;
                        state  <= HI;
                    end else begin
                        // Nothing has been taken for this word yet, so let go.
                        state <= IDLE;
                    end
                end
                HI: begin
                    // A half-received word is never abandoned: without a request, hold here.
                    if (req_own) begin
                        burst_cnt <= burst_cnt + 5'd1;
                        if (burst_done) begin
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            state <= LO;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load a packed word, or drop valid once it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else if (load) begin
            out_vld_q  <= 1'b1;
            out_data_q <= {dat_own, lo_nib};
        end else if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    // Configuration register; a write also clears the service counters below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg <= CFG_RST;
        end else if (bus.cfg_we) begin
            cfg <= bus.cfg_data;
        end
    end

    // Saturating per-requester word counters; a configuration write wins over a completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else if (bus.cfg_we) begin
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (load && (owner == 2'(k)) && (cnt_q[k] != CNT_MAX)) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_data = out_data_q;
    assign bus.cnt0     = cnt_q[0];
    assign bus.cnt1     = cnt_q[1];
    assign bus.cnt2     = cnt_q[2];

endmodule
